// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: on start, emits pkt_len beats counting up from seed,
// flags the last beat with tlast, then pulses done and bumps a packet counter.
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_count,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  busy_q;
    logic                  done_q;
    logic [15:0]           cnt_q;

    logic [LEN_WIDTH-1:0]  beat_d;
    logic                  tlast_d;

    // Look-ahead so tlast is registered together with the beat it marks.
    assign beat_d  = beat_q + LEN_WIDTH'(1);
    assign tlast_d = (beat_d == len_q - LEN_WIDTH'(1));

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        state_q  <= SEND;
                        len_q    <= pkt_len;
                        beat_q   <= '0;
                        data_q   <= seed;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (pkt_len == LEN_WIDTH'(1));
                        busy_q   <= 1'b1;
                    end
                end
                SEND: begin
                    // Without a handshake nothing moves, which holds the beat stable.
                    if (m_axis_tready) begin
                        if (tlast_q) begin
                            state_q  <= IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            cnt_q    <= cnt_q + 16'd1;
                        end else begin
                            beat_q  <= beat_d;
                            data_q  <= data_q + DATA_WIDTH'(1);
                            tlast_q <= tlast_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = cnt_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed and random-ready bench for axis_pkt_gen; inputs are driven and outputs
// sampled 1 ns after each rising edge.
module tb_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] pkt_len;
    logic [7:0]  seed;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;

    int n_checks = 0;
    int n_errors = 0;

    axis_pkt_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pkt_len       (pkt_len),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .pkt_count     (pkt_count),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] data, input logic last);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_tdata"},  32'(m_axis_tdata),  32'(data));
        check({tag, "_tlast"},  32'(m_axis_tlast),  32'(last));
        check({tag, "_busy"},   32'(busy),          32'd1);
        check({tag, "_done"},   32'(done),          32'd0);
    endtask

    task automatic check_done(input string tag, input logic [15:0] cnt);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        check({tag, "_busy"},   32'(busy),          32'd0);
        check({tag, "_done"},   32'(done),          32'd1);
        check({tag, "_count"},  32'(pkt_count),     32'(cnt));
    endtask

    task automatic do_start(input logic [15:0] len, input logic [7:0] s);
        start   = 1'b1;
        pkt_len = len;
        seed    = s;
        tick();
        start   = 1'b0;
        pkt_len = 16'hBEEF;
        seed    = 8'h3C;
    endtask

    initial begin
        logic [15:0] exp_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        pkt_len = '0;
        seed = '0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_tlast",  32'(m_axis_tlast),  32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_done",   32'(done),          32'd0);
        check("rst_count",  32'(pkt_count),     32'd0);
        rst_n = 1'b1;
        tick();

        // Four beats at full rate.
        do_start(16'd4, 8'h10);
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("p4_b%0d", i), 8'(8'h10 + i), i == 3);
            tick();
        end
        check_done("p4_end", 16'd1);
        tick();
        check("p4_done_pulse", 32'(done), 32'd0);

        // Three beats with two stall cycles each, wrapping the data.
        m_axis_tready = 1'b0;
        do_start(16'd3, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 3; s++) begin
                check_beat($sformatf("stall_b%0d_s%0d", i, s), 8'(8'hFE + i), i == 2);
                if (s == 2) m_axis_tready = 1'b1;
                tick();
            end
            m_axis_tready = 1'b0;
        end
        check_done("stall_end", 16'd2);
        m_axis_tready = 1'b1;
        tick();

        // Single beat, then a zero-length request that must be ignored.
        do_start(16'd1, 8'hA5);
        check_beat("p1_b0", 8'hA5, 1'b1);
        tick();
        check_done("p1_end", 16'd3);
        tick();
        do_start(16'd0, 8'h55);
        check("len0_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("len0_busy",   32'(busy),          32'd0);
        tick();
        check("len0_done",   32'(done),          32'd0);
        check("len0_count",  32'(pkt_count),     32'd3);

        // start held high: one idle cycle between packets.
        start = 1'b1;
        pkt_len = 16'd2;
        seed = 8'h20;
        tick();
        for (int p = 0; p < 3; p++) begin
            check_beat($sformatf("b2b%0d_b0", p), 8'h20, 1'b0);
            tick();
            check_beat($sformatf("b2b%0d_b1", p), 8'h21, 1'b1);
            tick();
            check_done($sformatf("b2b%0d_end", p), 16'(4 + p));
            if (p == 2) start = 1'b0;
            tick();
        end
        check("b2b_stop_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Reset mid-packet, with start asserted at the reset edge.
        do_start(16'd8, 8'h40);
        check_beat("rstmid_b0", 8'h40, 1'b0);
        tick();
        check_beat("rstmid_b1", 8'h41, 1'b0);
        tick();
        check_beat("rstmid_b2", 8'h42, 1'b0);
        rst_n = 1'b0;
        start = 1'b1;
        pkt_len = 16'd5;
        seed = 8'h99;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rstmid_busy",   32'(busy),          32'd0);
        check("rstmid_count",  32'(pkt_count),     32'd0);
        tick();
        check("rstmid_no_start", 32'(m_axis_tvalid), 32'd0);
        check("rstmid_no_done",  32'(done),          32'd0);
        do_start(16'd3, 8'h70);
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("post_rst_b%0d", i), 8'(8'h70 + i), i == 2);
            tick();
        end
        check_done("post_rst_end", 16'd1);

        // Random ready over 1000 packets with a reference model and stall checks.
        exp_cnt = 16'd1;
        for (int p = 0; p < 1000; p++) begin
            logic [15:0] len;
            logic [7:0]  s;
            logic [7:0]  prev_data;
            logic        prev_last;
            logic        rdy;
            int          beat;
            int          cycles;
            len = 16'($urandom_range(1, 4));
            s   = 8'($urandom);
            m_axis_tready = 1'($urandom);
            do_start(len, s);
            beat = 0;
            cycles = 0;
            while (beat < int'(len) && cycles < 200) begin
                rdy = 1'($urandom);
                m_axis_tready = rdy;
                check("rnd_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("rnd_tdata",  32'(m_axis_tdata),  32'(8'(s + beat)));
                check("rnd_tlast",  32'(m_axis_tlast),  32'(beat == int'(len) - 1));
                prev_data = m_axis_tdata;
                prev_last = m_axis_tlast;
                tick();
                cycles++;
                if (rdy) begin
                    beat++;
                end else begin
                    check("rnd_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                    check("rnd_stall_tdata",  32'(m_axis_tdata),  32'(prev_data));
                    check("rnd_stall_tlast",  32'(m_axis_tlast),  32'(prev_last));
                end
            end
            check("rnd_beats_done", 32'(beat), 32'(len));
            exp_cnt = exp_cnt + 16'd1;
            check("rnd_end_done",   32'(done),          32'd1);
            check("rnd_end_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("rnd_end_count",  32'(pkt_count),     32'(exp_cnt));
        end
        tick();
        check("final_count", 32'(pkt_count), 32'(16'(1001)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
